// File: rtl/fp_acc_sat_if.sv
// Handshake bundle between the multiplier output stage and the frame accumulator,
// and from the accumulator to its result consumer.
interface fp_acc_sat_if #(
    parameter int W_in  = 16,
    parameter int W_out = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [W_in-1:0]  in_data;
    logic             in_ovf;
    logic             in_unf;
    logic             out_valid;
    logic             out_ready;
    logic [W_out-1:0] out_data;
    logic             out_sat;
    logic             out_ovf_seen;
    logic             out_unf_seen;

    modport slave (
        input  in_valid, in_data, in_ovf, in_unf, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_ovf_seen, out_unf_seen
    );

    modport master (
        output in_valid, in_data, in_ovf, in_unf, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_ovf_seen, out_unf_seen
    );
endinterface

// File: rtl/fp_acc_sat.sv
// Frame accumulator after the fixed-point multiplier: sums N_ACC products in a wide
// accumulator, saturates to the output format and holds the result until taken.
module fp_acc_sat #(
    parameter int W_in    = 16,
    parameter int W_in_F  = 14,
    parameter int W_out   = 16,
    parameter int W_out_F = 14,
    parameter int N_ACC   = 8,
    parameter int W_acc   = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    fp_acc_sat_if.slave   bus
);

    localparam int CNT_W = $clog2(N_ACC);

    if (W_out_F != W_in_F) begin : g_chk_frac
        $error("fp_acc_sat: W_out_F must equal W_in_F");
    end
    if (N_ACC < 2) begin : g_chk_nacc
        $error("fp_acc_sat: N_ACC must be at least 2");
    end
    if (W_acc < W_in + $clog2(N_ACC)) begin : g_chk_wacc
        $error("fp_acc_sat: W_acc too narrow for N_ACC products");
    end
    if (W_acc < W_out) begin : g_chk_wout
        $error("fp_acc_sat: W_acc must be at least W_out");
    end

    localparam logic signed [W_acc-1:0] IN_MAX  = {{(W_acc-W_in+1){1'b0}},  {(W_in-1){1'b1}}};
    localparam logic signed [W_acc-1:0] IN_MIN  = {{(W_acc-W_in+1){1'b1}},  {(W_in-1){1'b0}}};
    localparam logic signed [W_acc-1:0] OUT_MAX = {{(W_acc-W_out+1){1'b0}}, {(W_out-1){1'b1}}};
    localparam logic signed [W_acc-1:0] OUT_MIN = {{(W_acc-W_out+1){1'b1}}, {(W_out-1){1'b0}}};
    localparam logic [CNT_W-1:0]        LAST    = CNT_W'(N_ACC - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    // A flagged product has already wrapped upstream, so substitute the rail value.
    function automatic logic signed [W_acc-1:0] sample_val(input logic [W_in-1:0] d,
                                                           input logic ovf,
                                                           input logic unf);
        if (ovf) return IN_MAX;
        if (unf) return IN_MIN;
        return {{(W_acc-W_in){d[W_in-1]}}, d};
    endfunction

    // Returns {clamped, value}.
    function automatic logic [W_out:0] sat_out(input logic signed [W_acc-1:0] x);
        if (x > OUT_MAX) return {1'b1, OUT_MAX[W_out-1:0]};
        if (x < OUT_MIN) return {1'b1, OUT_MIN[W_out-1:0]};
        return {1'b0, x[W_out-1:0]};
    endfunction

    state_t                   state_q, state_d;
    logic signed [W_acc-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_stk_q, ovf_stk_d;
    logic                     unf_stk_q, unf_stk_d;
    logic [W_out-1:0]         out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;
    logic                     out_ovf_q, out_ovf_d;
    logic                     out_unf_q, out_unf_d;

    logic signed [W_acc-1:0]  sample;
    logic signed [W_acc-1:0]  sum;
    logic [W_out:0]           sat_r;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_stk_d  = ovf_stk_q;
        unf_stk_d  = unf_stk_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        out_ovf_d  = out_ovf_q;
        out_unf_d  = out_unf_q;

        sample = sample_val(bus.in_data, bus.in_ovf, bus.in_unf);
        sum    = acc_q + sample;
        sat_r  = sat_out(sum);

        if (clear) begin
            state_d   = ACCUM;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_stk_d = 1'b0;
            unf_stk_d = 1'b0;
        end else if (state_q == ACCUM) begin
            if (bus.in_valid) begin
                if (cnt_q == LAST) begin
                    out_data_d = sat_r[W_out-1:0];
                    out_sat_d  = sat_r[W_out];
                    out_ovf_d  = ovf_stk_q | bus.in_ovf;
                    out_unf_d  = unf_stk_q | bus.in_unf;
                    state_d    = HOLD;
                    acc_d      = '0;
                    cnt_d      = '0;
                    ovf_stk_d  = 1'b0;
                    unf_stk_d  = 1'b0;
                end else begin
                    acc_d     = sum;
                    cnt_d     = cnt_q + CNT_W'(1);
                    ovf_stk_d = ovf_stk_q | bus.in_ovf;
                    unf_stk_d = unf_stk_q | bus.in_unf;
                end
            end
        end else if (bus.out_ready) begin
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_stk_q  <= 1'b0;
            unf_stk_q  <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            out_ovf_q  <= 1'b0;
            out_unf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_stk_q  <= ovf_stk_d;
            unf_stk_q  <= unf_stk_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            out_ovf_q  <= out_ovf_d;
            out_unf_q  <= out_unf_d;
        end
    end

    assign bus.in_ready     = (state_q == ACCUM);
    assign bus.out_valid    = (state_q == HOLD);
    assign bus.out_data     = out_data_q;
    assign bus.out_sat      = out_sat_q;
    assign bus.out_ovf_seen = out_ovf_q;
    assign bus.out_unf_seen = out_unf_q;

endmodule

// File: tb/tb_fp_acc_sat.sv
// Bench for fp_acc_sat with N_ACC=4: directed frames, a frame-level reference model
// compared every cycle, and literal expectations for each frame result.
module tb_fp_acc_sat;

    localparam int W_IN  = 16;
    localparam int W_OUT = 16;
    localparam int N     = 4;
    localparam int IMAX  = 2**(W_IN-1) - 1;
    localparam int IMIN  = -(2**(W_IN-1));
    localparam int OMAX  = 2**(W_OUT-1) - 1;
    localparam int OMIN  = -(2**(W_OUT-1));

    logic clk;
    logic rst_n;
    logic clear;
    int   checks;
    int   errors;

    fp_acc_sat_if #(.W_in(W_IN), .W_out(W_OUT)) bus ();

    fp_acc_sat #(
        .W_in(W_IN), .W_in_F(14), .W_out(W_OUT), .W_out_F(14), .N_ACC(N), .W_acc(24)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame sum as a plain integer, clamped on completion.
    int m_acc, m_cnt, m_out_data;
    bit m_ovf, m_unf, m_hold, m_sat, m_oovf, m_ounf;

    function automatic int m_sample(input logic [W_IN-1:0] d, input bit ovf, input bit unf);
        if (ovf) return IMAX;
        if (unf) return IMIN;
        return int'($signed(d));
    endfunction

    function automatic int m_clamp(input int x);
        if (x > OMAX) return OMAX;
        if (x < OMIN) return OMIN;
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc <= 0; m_cnt <= 0; m_ovf <= 0; m_unf <= 0; m_hold <= 0;
            m_out_data <= 0; m_sat <= 0; m_oovf <= 0; m_ounf <= 0;
        end else if (clear) begin
            m_acc <= 0; m_cnt <= 0; m_ovf <= 0; m_unf <= 0; m_hold <= 0;
        end else if (m_hold) begin
            if (bus.out_ready) m_hold <= 0;
        end else if (bus.in_valid) begin
            if (m_cnt == N - 1) begin
                m_out_data <= m_clamp(m_acc + m_sample(bus.in_data, bus.in_ovf, bus.in_unf));
                m_sat  <= (m_clamp(m_acc + m_sample(bus.in_data, bus.in_ovf, bus.in_unf))
                           != m_acc + m_sample(bus.in_data, bus.in_ovf, bus.in_unf));
                m_oovf <= m_ovf | bus.in_ovf;
                m_ounf <= m_unf | bus.in_unf;
                m_hold <= 1;
                m_acc <= 0; m_cnt <= 0; m_ovf <= 0; m_unf <= 0;
            end else begin
                m_acc <= m_acc + m_sample(bus.in_data, bus.in_ovf, bus.in_unf);
                m_cnt <= m_cnt + 1;
                m_ovf <= m_ovf | bus.in_ovf;
                m_unf <= m_unf | bus.in_unf;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_in_ready",  int'(bus.in_ready),  int'(!m_hold));
        chk("cyc_out_valid", int'(bus.out_valid), int'(m_hold));
        chk("cyc_out_data",  int'($signed(bus.out_data)), m_out_data);
        chk("cyc_out_sat",   int'(bus.out_sat),   int'(m_sat));
        chk("cyc_ovf_seen",  int'(bus.out_ovf_seen), int'(m_oovf));
        chk("cyc_unf_seen",  int'(bus.out_unf_seen), int'(m_ounf));
    end

    // Present one sample and hold it until the DUT takes it.
    task automatic send(input logic [15:0] d, input bit ovf, input bit unf);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_ovf   = ovf;
        bus.in_unf   = unf;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        bus.in_ovf   = 1'b0;
        bus.in_unf   = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [15:0] d,
                                 input bit sat, input bit ovf, input bit unf);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk({name, "_valid"}, int'(bus.out_valid), 1);
        chk({name, "_data"},  int'(bus.out_data), int'(d));
        chk({name, "_sat"},   int'(bus.out_sat), int'(sat));
        chk({name, "_ovf"},   int'(bus.out_ovf_seen), int'(ovf));
        chk({name, "_unf"},   int'(bus.out_unf_seen), int'(unf));
        bus.out_ready = 1'b1;
        @(posedge clk); #2;
        bus.out_ready = 1'b0;
        chk({name, "_drop"},  int'(bus.out_valid), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_ovf    = 1'b0;
        bus.in_unf    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        chk("rst_in_ready",  int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data",  int'(bus.out_data), 0);

        // Plain sum, and the result appears right after the last accept.
        repeat (N) send(16'h1000, 0, 0);
        chk("lat_valid", int'(bus.out_valid), 1);
        expect_result("sum_quarter", 16'h4000, 0, 0, 0);

        repeat (N) send(16'h4000, 0, 0);
        expect_result("sat_pos", 16'h7FFF, 1, 0, 0);
        repeat (N) send(16'hC000, 0, 0);
        expect_result("sat_neg", 16'h8000, 1, 0, 0);

        send(16'h0400, 0, 0);
        send(16'h1234, 1, 0);
        send(16'hF000, 0, 0);
        send(16'h0000, 0, 0);
        expect_result("ovf_sub", 16'h73FF, 0, 1, 0);

        // Underflow substitution, and ovf wins when both flags are set.
        send(16'h1234, 0, 1);
        send(16'h0100, 0, 0);
        send(16'h0100, 0, 0);
        send(16'h5555, 1, 1);
        expect_result("both_flags", 16'h01FF, 0, 1, 1);

        // Backpressure: result held, input blocked while in_valid stays high.
        repeat (N) send(16'h1000, 0, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h7000;
        repeat (5) begin
            @(posedge clk); #2;
            chk("hold_in_ready",  int'(bus.in_ready), 0);
            chk("hold_out_valid", int'(bus.out_valid), 1);
            chk("hold_out_data",  int'(bus.out_data), 16'h4000);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #2;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("hs_in_ready",  int'(bus.in_ready), 1);
        chk("hs_out_valid", int'(bus.out_valid), 0);
        chk("hs_data_kept", int'(bus.out_data), 16'h4000);
        repeat (N) send(16'h0200, 0, 0);
        expect_result("after_hold", 16'h0800, 0, 0, 0);

        // Asynchronous reset in the middle of a frame.
        send(16'h2000, 0, 0);
        send(16'h2000, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_data",  int'(bus.out_data), 0);
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_in_ready",  int'(bus.in_ready), 1);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #2;
        repeat (N) send(16'h0400, 0, 0);
        expect_result("post_rst", 16'h1000, 0, 0, 0);

        // Clear mid-frame drops partial sum, sticky flags and the concurrent sample.
        send(16'h2000, 0, 0);
        send(16'h2000, 1, 0);
        send(16'h2000, 0, 0);
        clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h2000;
        @(posedge clk); #2;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        repeat (N) send(16'h0100, 0, 0);
        expect_result("post_clear", 16'h0400, 0, 0, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
